// File: rtl/fini_pkg.sv
// Shared constants, lane type and codeword lookup for the FINI multiply-and-detect pipe.
// Lookup runs on a fixed-size table so one function serves every supported N.
package fini_pkg;

   localparam int FINI_N = 5;
   localparam logic [2**FINI_N-1:0] FINI_CODE_TABLE = 32'h0080_0081;

   // Upper bound on N so the lookup helper can use one fixed table width
   localparam int FINI_MAX_N   = 8;
   localparam int FINI_MAX_TBL = 2**FINI_MAX_N;

   typedef logic [FINI_N-1:0] lane_t;

   function automatic logic is_codeword(input logic [FINI_MAX_TBL-1:0] tbl,
                                        input logic [FINI_MAX_N-1:0]   value);
      return tbl[value];
   endfunction

endpackage

// File: rtl/fini_lane_check.sv
// One lane of the FINI cell: AND-multiply two codewords and flag a non-codeword product.
// Purely combinational; the caller registers the product and the flag.
module fini_lane_check
   import fini_pkg::*;
#(
   parameter int                N          = FINI_N,
   parameter logic [2**N-1:0]   CODE_TABLE = FINI_CODE_TABLE
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] p,
   output logic         err
);

   logic [FINI_MAX_TBL-1:0] tbl_ext;
   logic [FINI_MAX_N-1:0]   idx_ext;

   always_comb begin
      p                  = a & b;
      tbl_ext            = '0;
      tbl_ext[2**N-1:0]  = CODE_TABLE;
      idx_ext            = '0;
      idx_ext[N-1:0]     = p;
      err                = ~is_codeword(tbl_ext, idx_ext);
   end

endmodule

// File: rtl/fini_detection_pipe.sv
// Pipelined multi-lane FINI multiply-and-detect with per-beat error flags,
// sticky alarm, saturating error-beat counter and optional masking of bad lanes.
module fini_detection_pipe
   import fini_pkg::*;
#(
   parameter int N             = FINI_N,
   parameter int LANES         = 1,
   parameter int STAGES        = 2,
   parameter     CODE_TABLE    = FINI_CODE_TABLE,
   parameter bit MASK_ON_ERROR = 1'b0,
   parameter int CNT_W         = 8
) (
   input  logic               port_clk,
   input  logic               port_rst,
   input  logic               port_in_valid,
   input  logic [LANES*N-1:0] port_a,
   input  logic [LANES*N-1:0] port_b,
   input  logic               port_clear,
   output logic               port_out_valid,
   output logic [LANES*N-1:0] port_c,
   output logic [LANES-1:0]   port_errorFlag,
   output logic               port_errorSticky,
   output logic [CNT_W-1:0]   port_errCount
);

   localparam int W = LANES * N;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if ($bits(CODE_TABLE) != 2**N) begin : g_bad_table
      $error("fini_detection_pipe: CODE_TABLE width must equal 2**N");
   end
   if (N < 2 || N > FINI_MAX_N) begin : g_bad_n
      $error("fini_detection_pipe: N out of supported range");
   end
   if (LANES < 1 || STAGES < 1 || CNT_W < 1) begin : g_bad_dims
      $error("fini_detection_pipe: LANES, STAGES and CNT_W must be >= 1");
   end

   logic [W-1:0]     prod_in;
   logic [LANES-1:0] err_in;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fini_lane_check #(
         .N          (N),
         .CODE_TABLE (CODE_TABLE)
      ) u_lane (
         .a   (port_a[i*N +: N]),
         .b   (port_b[i*N +: N]),
         .p   (prod_in[i*N +: N]),
         .err (err_in[i])
      );
   end

   logic [STAGES-1:0] vld_q;
   logic [W-1:0]      prod_q [STAGES];
   logic [LANES-1:0]  err_q  [STAGES];

   // Data registers only load behind a valid bit so bubbles leave the last beat visible
   always_ff @(posedge port_clk or posedge port_rst) begin
      if (port_rst) begin
         vld_q <= '0;
         for (int s = 0; s < STAGES; s++) begin
            prod_q[s] <= '0;
            err_q[s]  <= '0;
         end
      end else begin
         vld_q[0] <= port_in_valid;
         if (port_in_valid) begin
            prod_q[0] <= prod_in;
            err_q[0]  <= err_in;
         end
         for (int s = 1; s < STAGES; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) begin
               prod_q[s] <= prod_q[s-1];
               err_q[s]  <= err_q[s-1];
            end
         end
      end
   end

   // Accumulation looks at what the last stage is about to load, so the alarm
   // and counter update on the same edge that raises out_valid for that beat.
   logic             fin_vld_in;
   logic [LANES-1:0] fin_err_in;

   if (STAGES == 1) begin : g_fin_direct
      assign fin_vld_in = port_in_valid;
      assign fin_err_in = err_in;
   end else begin : g_fin_piped
      assign fin_vld_in = vld_q[STAGES-2];
      assign fin_err_in = err_q[STAGES-2];
   end

   logic             err_beat;
   logic             sticky_q;
   logic [CNT_W-1:0] cnt_q;

   assign err_beat = fin_vld_in & (|fin_err_in);

   always_ff @(posedge port_clk or posedge port_rst) begin
      if (port_rst) begin
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (err_beat) begin
            sticky_q <= 1'b1;
         end else if (port_clear) begin
            sticky_q <= 1'b0;
         end

         if (port_clear) begin
            cnt_q <= err_beat ? CNT_ONE : '0;
         end else if (err_beat && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   always_comb begin
      port_c = prod_q[STAGES-1];
      if (MASK_ON_ERROR) begin
         for (int l = 0; l < LANES; l++) begin
            if (err_q[STAGES-1][l]) begin
               port_c[l*N +: N] = '0;
            end
         end
      end
      port_errorFlag = vld_q[STAGES-1] ? err_q[STAGES-1] : '0;
   end

   assign port_out_valid   = vld_q[STAGES-1];
   assign port_errorSticky = sticky_q;
   assign port_errCount    = cnt_q;

endmodule

// File: tb/tb_fini_detection_pipe.sv
// Scoreboard bench for fini_detection_pipe: 2 lanes of 5 bits, 2 stages, masking on, 2-bit counter.
module tb_fini_detection_pipe;
   import fini_pkg::*;

   localparam int N      = 5;
   localparam int LANES  = 2;
   localparam int STAGES = 2;
   localparam int CNT_W  = 2;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic [LANES*N-1:0] a;
   logic [LANES*N-1:0] b;
   logic               clear;
   logic               out_valid;
   logic [LANES*N-1:0] c;
   logic [LANES-1:0]   err_flag;
   logic               sticky;
   logic [CNT_W-1:0]   err_cnt;

   fini_detection_pipe #(
      .N             (N),
      .LANES         (LANES),
      .STAGES        (STAGES),
      .CODE_TABLE    (32'h0080_0081),
      .MASK_ON_ERROR (1'b1),
      .CNT_W         (CNT_W)
   ) dut (
      .port_clk         (clk),
      .port_rst         (rst),
      .port_in_valid    (in_valid),
      .port_a           (a),
      .port_b           (b),
      .port_clear       (clear),
      .port_out_valid   (out_valid),
      .port_c           (c),
      .port_errorFlag   (err_flag),
      .port_errorSticky (sticky),
      .port_errCount    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [LANES*N-1:0] c;
      logic [LANES-1:0]   flag;
      logic               sticky;
      logic [CNT_W-1:0]   cnt;
   } exp_t;

   exp_t               sb[$];
   int                 n_pass  = 0;
   int                 n_total = 0;
   logic               mon_en  = 1'b0;
   logic [LANES*N-1:0] last_c  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [LANES*N-1:0] pk(input lane_t l1, input lane_t l0);
      return {l1, l0};
   endfunction

   task automatic push(input logic [LANES*N-1:0] ec, input logic [LANES-1:0] ef,
                       input logic es, input logic [CNT_W-1:0] en);
      exp_t e;
      e.c = ec; e.flag = ef; e.sticky = es; e.cnt = en;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [LANES*N-1:0] ia, input logic [LANES*N-1:0] ib,
                        input logic iv, input logic iclr);
      a = ia; b = ib; in_valid = iv; clear = iclr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue('0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: pops one expectation per output beat; checks bubble behaviour otherwise
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("beat_c",      {22'b0, c},        {22'b0, e.c});
               check("beat_flag",   {30'b0, err_flag}, {30'b0, e.flag});
               check("beat_sticky", {31'b0, sticky},   {31'b0, e.sticky});
               check("beat_count",  {30'b0, err_cnt},  {30'b0, e.cnt});
               last_c = e.c;
            end
         end else begin
            check("bubble_flag_zero", {30'b0, err_flag}, 32'd0);
            check("bubble_c_hold",    {22'b0, c},        {22'b0, last_c});
         end
      end
   end

   initial begin : stim
      int n;
      rst = 1'b0; clear = 1'b0;
      in_valid = 1'b1;
      a = LANES*N'($urandom);
      b = LANES*N'($urandom);

      // 1: asynchronous reset with random traffic already flowing
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      a = LANES*N'($urandom);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_c",         {22'b0, c},         32'd0);
      check("rst_flag",      {30'b0, err_flag},  32'd0);
      check("rst_sticky",    {31'b0, sticky},    32'd0);
      check("rst_count",     {30'b0, err_cnt},   32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      last_c = '0;
      mon_en = 1'b1;

      // 2: clean beat, both products valid codewords (23 and 7)
      push(pk(5'h07, 5'h17), 2'b00, 1'b0, 2'd0);
      issue(pk(5'h07, 5'h17), pk(5'h0F, 5'h1F), 1'b1, 1'b0);
      idle(3);

      // 3: lane0 product 15 is bad and masked; following clean beat keeps alarm state
      push(pk(5'h07, 5'h00), 2'b01, 1'b1, 2'd1);
      issue(pk(5'h07, 5'h1F), pk(5'h07, 5'h0F), 1'b1, 1'b0);
      push(pk(5'h07, 5'h17), 2'b00, 1'b1, 2'd1);
      issue(pk(5'h07, 5'h17), pk(5'h0F, 5'h1F), 1'b1, 1'b0);
      idle(3);

      issue('0, '0, 1'b0, 1'b1);
      check("clear_idle_sticky", {31'b0, sticky},  32'd0);
      check("clear_idle_count",  {30'b0, err_cnt}, 32'd0);

      // both lanes bad in one beat still count once
      push(pk(5'h00, 5'h00), 2'b11, 1'b1, 2'd1);
      issue(pk(5'h1F, 5'h1F), pk(5'h0F, 5'h0F), 1'b1, 1'b0);
      idle(3);
      issue('0, '0, 1'b0, 1'b1);

      // 4: saturation of the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         push(pk(5'h00, 5'h00), 2'b01, 1'b1, (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3);
         issue(pk(5'h00, 5'h1F), pk(5'h00, 5'h0F), 1'b1, 1'b0);
      end
      idle(3);
      check("sat_count",  {30'b0, err_cnt}, 32'd3);
      check("sat_sticky", {31'b0, sticky},  32'd1);

      // 5: clear on the same edge as an erroneous output beat; lane1 bad this time
      push(pk(5'h00, 5'h17), 2'b10, 1'b1, 2'd1);
      issue(pk(5'h1F, 5'h17), pk(5'h0F, 5'h17), 1'b1, 1'b0);
      issue('0, '0, 1'b0, 1'b1);
      idle(2);
      check("collide_count",  {30'b0, err_cnt}, 32'd1);
      check("collide_sticky", {31'b0, sticky},  32'd1);
      issue('0, '0, 1'b0, 1'b1);
      check("clear2_sticky", {31'b0, sticky},  32'd0);
      check("clear2_count",  {30'b0, err_cnt}, 32'd0);
      idle(2);

      // 6: half-cycle reset spanning the edge kills both in-flight beats
      a = pk(5'h07, 5'h17); b = pk(5'h07, 5'h17); in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = pk(5'h1F, 5'h1F); b = pk(5'h0F, 5'h0F);
      #7;
      rst = 1'b1;
      last_c = '0;
      #5;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_sticky",    {31'b0, sticky},    32'd0);
      check("midrst_count",     {30'b0, err_cnt},   32'd0);
      @(posedge clk);
      #1;
      idle(3);

      push(pk(5'h00, 5'h00), 2'b10, 1'b1, 2'd1);
      a = pk(5'h1C, 5'h0A); b = pk(5'h07, 5'h05); in_valid = 1'b1;
      n = 0;
      while (n < 10) begin
         @(posedge clk);
         n++;
         #1;
         in_valid = 1'b0;
         if (out_valid) break;
      end
      check("latency_edges", n, STAGES);
      idle(3);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
